// File: rtl/aoc_char_feeder.sv
// Byte-stream front end: FWFT FIFO with CR strip, guaranteed trailing LF and end-of-stream flag.
// Build option: define AOC_CHAR_FEEDER_CR_STRIP_EN to discard 8'h0D on input.
module aoc_char_feeder #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_char,
  input  logic        out_ready,
  output logic        done,
  output logic [31:0] byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // IDLE: post-reset hold-off, RUN: accept, APPEND: add final LF, DRAIN: empty FIFO, DONE: terminal
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_APPEND,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              line_open_q, line_open_d;
  logic [31:0]       byte_count_q, byte_count_d;

  logic              full, empty, accept, pop, cr_drop, wr_en, drained_next;
  logic [7:0]        wr_data;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign in_ready   = (state_q == ST_RUN) && !full;
  assign accept     = in_valid && in_ready;
  assign out_valid  = !empty;
  assign out_char   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop        = out_valid && out_ready;
  assign done       = (state_q == ST_DONE);
  assign byte_count = byte_count_q;

  // Occupancy after this edge is zero: nothing stored, or the only entry is leaving now.
  assign drained_next = empty || ((count_q == (AW+1)'(1)) && pop);

`ifdef AOC_CHAR_FEEDER_CR_STRIP_EN
  assign cr_drop = (in_char == 8'h0D);
`else
  assign cr_drop = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    line_open_d = line_open_q;
    wr_en       = 1'b0;
    wr_data     = in_char;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          wr_en = !cr_drop;
          if (!cr_drop) line_open_d = (in_char != 8'h0A);
          if (in_last) state_d = line_open_d ? ST_APPEND : ST_DRAIN;
        end
      end
      ST_APPEND: begin
        wr_data = 8'h0A;
        if (!full) begin
          wr_en       = 1'b1;
          line_open_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained_next) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    byte_count_d = byte_count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (byte_count_q != 32'hFFFF_FFFF) byte_count_d = byte_count_q + 32'd1;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      line_open_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      line_open_q  <= line_open_d;
      byte_count_q <= byte_count_d;
    end
  end

  // Storage needs no reset: out_char is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_aoc_char_feeder.sv
// Randomized self-checking bench for aoc_char_feeder against a queue-based line-ending model.
// Follows AOC_CHAR_FEEDER_CR_STRIP_EN the same way as the design build.
module tb_aoc_char_feeder;

  localparam int DEPTH = 4;
`ifdef AOC_CHAR_FEEDER_CR_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready = 1'b0;
  logic        done;
  logic [31:0] byte_count;

  aoc_char_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_pop = 0;
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void set_stim(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endfunction

  function automatic void rand_stim();
    int len;
    int r;
    stim_q.delete();
    len = $urandom_range(20, 1);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(9);
      if (r == 0)      stim_q.push_back(8'h0A);
      else if (r == 1) stim_q.push_back(8'h0D);
      else if (r == 2) stim_q.push_back(8'h20);
      else             stim_q.push_back(8'h61 + 8'($urandom_range(25)));
    end
  endfunction

  // Expected downstream stream: drop CRs when stripping, append LF if the last line is unterminated.
  function automatic void build_exp();
    bit open = 1'b0;
    exp_q.delete();
    foreach (stim_q[k]) begin
      if (STRIP && stim_q[k] == 8'h0D) continue;
      exp_q.push_back(stim_q[k]);
      open = (stim_q[k] != 8'h0A);
    end
    if (open) exp_q.push_back(8'h0A);
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_done", done, 0);
    chk("rst_byte_count", byte_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    n_wr  = 0;
    n_pop = 0;
  endtask

  task automatic drive_stream(input int gap_pct);
    int  i = 0;
    int  cyc = 0;
    bit  ended = 1'b0;
    bit  acc;
    while (!ended && cyc < 2000) begin
      @(negedge clk);
      chk("in_ready", in_ready, ((n_wr - n_pop) < DEPTH) ? 1 : 0);
      if ($urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_char  = stim_q[i];
        in_last  = (i == stim_q.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_char  = 8'($urandom);
        in_last  = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        if (!(STRIP && stim_q[i] == 8'h0D)) n_wr++;
        if (i == stim_q.size() - 1) ended = 1'b1;
        i++;
      end
      cyc++;
    end
    if (!ended) chk("drive_timeout", i, stim_q.size());
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic monitor_stream(input int stall_pct, input int hold);
    int idx = 0;
    int cyc = 0;
    int w = 0;
    bit pop;
    if (exp_q.size() == 0) begin
      out_ready = 1'b1;
      while (!done && w < 20) begin
        @(negedge clk);
        chk("empty_out_valid", out_valid, 0);
        w++;
      end
      chk("empty_done", done, 1);
    end else begin
      while (cyc < 2000) begin
        @(negedge clk);
        out_ready = (cyc >= hold) && ($urandom_range(99) >= stall_pct);
        chk("done", done, (idx == exp_q.size()) ? 1 : 0);
        if (idx == exp_q.size()) break;
        if (out_valid) chk("out_char", out_char, exp_q[idx]);
        pop = out_valid && out_ready;
        @(posedge clk);
        if (pop) begin
          idx++;
          n_pop++;
        end
        cyc++;
      end
      if (idx != exp_q.size()) chk("drain_timeout", idx, exp_q.size());
    end
    chk("byte_count", byte_count, exp_q.size());
  endtask

  task automatic run_stream(input int gap_pct, input int stall_pct, input int hold);
    logic [31:0] bc;
    do_reset();
    build_exp();
    fork
      drive_stream(gap_pct);
      monitor_stream(stall_pct, hold);
    join
    bc = byte_count;
    chk("bc_stable_ref", bc, exp_q.size());
    repeat (3) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_char   = 8'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'b1;
      chk("done_in_ready", in_ready, 0);
      chk("done_out_valid", out_valid, 0);
      chk("done_sticky", done, 1);
      chk("done_byte_count", byte_count, exp_q.size());
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic mid_stream_reset();
    int accepted = 0;
    int guard = 0;
    bit acc;
    do_reset();
    set_stim("abcdefgh");
    while (accepted < 3 && guard < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = stim_q[accepted];
      in_last  = 1'b0;
      acc = in_ready;
      @(posedge clk);
      if (acc) accepted++;
      guard++;
    end
    chk("mid_accepted", accepted, 3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_char", out_char, 8'h61);
    #1 rst = 1'b1;
    #1;
    chk("async_in_ready", in_ready, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_char", out_char, 0);
    chk("async_done", done, 0);
    chk("async_byte_count", byte_count, 0);
  endtask

  initial begin
    do_reset();
    set_stim("1 red\n");
    run_stream(0, 0, 0);
    set_stim("ab");
    run_stream(0, 0, 0);
    set_stim("a\015\nb\015");
    run_stream(20, 20, 0);
    set_stim("xyz12\n");
    run_stream(0, 0, 15);
    set_stim("continuous\npush");
    run_stream(0, 0, 0);
    set_stim("\015");
    run_stream(0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      rand_stim();
      run_stream(30, 40, $urandom_range(8));
    end
    mid_stream_reset();
    set_stim("new\nstream");
    run_stream(10, 30, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
